// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmit and receive paths: frame FSM encoding,
// data width and bit-period helper.
package rs232_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rs232_state_e;

  // Integer division; caller guarantees the result is at least 2.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rs232_tx_fifo.sv
// Synchronous FIFO feeding the RS232 transmitter. Pointers carry one extra wrap bit so
// full and empty are distinguishable; level is the entry count.
module tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rs232_tx.sv
// RS232 transmitter: buffered 8N1 UART TX, LSB first, idle-high line.
// Define RS232_TX_PARITY_EN to insert a parity bit (even/odd via PARITY_ODD).
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      data,
  input  logic                            valid,
  output logic                            ready,
  output logic                            TX,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CntW       = $clog2(ClksPerBit);

  rs232_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 cnt_tc;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (valid),
    .wdata_i (data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign ready  = ~fifo_full;
  assign TX     = tx_q;
  assign busy   = (state_q != StIdle) || (level != '0);
  assign cnt_tc = (cnt_q == CntW'(ClksPerBit - 1));

`ifdef RS232_TX_PARITY_EN
  logic parity_q, parity_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  always_comb begin
    parity_d = parity_q;
    if (fifo_pop) parity_d = (^fifo_rdata) ^ (PARITY_ODD != 0);
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = ^PARITY_ODD;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          tx_d     = 1'b0;
          cnt_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (cnt_tc) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_tc) begin
          cnt_d = '0;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef RS232_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef RS232_TX_PARITY_EN
      StParity: begin
        if (cnt_tc) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_tc) begin
          cnt_d = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Scoreboard bench for rs232_tx at 12 MHz / 1 Mbaud (12 clocks per bit).
module tb_rs232_tx;

  localparam int unsigned CPB    = 12;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LW     = $clog2(DEPTH + 1);
  localparam int unsigned P_ODD  = 0;
`ifdef RS232_TX_PARITY_EN
  localparam int unsigned NBITS  = 11;
`else
  localparam int unsigned NBITS  = 10;
`endif
  localparam int unsigned FRAME  = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          valid = 1'b0;
  logic          ready, tx, busy;
  logic [LW-1:0] level;

  rs232_tx #(
    .CLK_HZ     (12000000),
    .BAUD       (1000000),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (P_ODD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .TX    (tx),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_pass = 0;
  int   n_checks = 0;
  logic [7:0]  exp_q[$];
  int unsigned frame_starts[$];
  int unsigned push_cyc;
  logic        track_en = 1'b0;
  int unsigned level_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!track_en) level_max = 0;
    else if (32'(level) > level_max) level_max = 32'(level);
  end

  // Monitor: capture each frame sample-by-sample, require every bit to be flat for CPB clocks.
  initial begin : monitor
    logic [10:0] bitv;
    logic        flat, aborted;
    logic [7:0]  got, want;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        frame_starts.push_back(cyc);
        bitv = '0;
        flat = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < int'(NBITS); b++) begin
          for (int s = 0; s < int'(CPB); s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            if (s == 0) bitv[b] = tx;
            else if (tx != bitv[b]) flat = 1'b0;
          end
        end
        if (!aborted) begin
          for (int i = 0; i < 8; i++) got[i] = bitv[1 + i];
          check("framing", {29'd0, flat, bitv[0], bitv[NBITS-1]}, 32'h5);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'd0, got}, 32'hFFFF_FFFF);
          end else begin
            want = exp_q.pop_front();
            check("frame_byte", {24'd0, got}, {24'd0, want});
`ifdef RS232_TX_PARITY_EN
            check("parity_bit", {31'd0, bitv[9]}, {31'd0, (^want) ^ (P_ODD != 0)});
`endif
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 5000) begin
      @(negedge clk);
      data  = b;
      valid = 1'b1;
      acc   = ready;
      @(posedge clk);
      #1;
      valid = 1'b0;
      tries++;
    end
    if (acc) begin
      exp_q.push_back(b);
      push_cyc = cyc;
    end else begin
      check("push_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (n < 4000)}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic        flat;
    int unsigned base, nacc, nframes;
    logic [7:0]  next;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_level", 32'(level), 32'd0);

    // 1. Quiet line for 200 clocks.
    flat = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || level !== '0) flat = 1'b0;
    end
    check("idle_200", {31'd0, flat}, 32'd1);

    // 2. Single byte, start-bit latency and busy release.
    base = frame_starts.size();
    push_byte(8'hA5);
    @(negedge clk);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    drain("drain_a5");
    check("a5_latency", frame_starts[base] - push_cyc, 32'd1);
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // 3. Three consecutive pushes, back-to-back frames.
    base = frame_starts.size();
    track_en = 1'b1;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    drain("drain_b2b");
    track_en = 1'b0;
    check("b2b_frames", frame_starts.size() - base, 32'd3);
    check("b2b_gap1", frame_starts[base+1] - frame_starts[base], FRAME);
    check("b2b_gap2", frame_starts[base+2] - frame_starts[base+1], FRAME);
    check("b2b_level_peak", level_max, 32'd2);

    // 4. Hold valid for 20 cycles; FIFO fills behind the frame in flight.
    base = frame_starts.size();
    nacc = 0;
    next = 8'h10;
    for (int c = 0; c < 20; c++) begin
      logic acc;
      @(negedge clk);
      data  = next;
      valid = 1'b1;
      acc   = ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(next);
        next++;
        nacc++;
      end
    end
    valid = 1'b0;
    @(negedge clk);
    check("fill_accepted", nacc, 32'd17);
    check("fill_ready_low", {31'd0, ready}, 32'd0);
    check("fill_level", 32'(level), DEPTH);
    drain("drain_fill");
    check("fill_frames", frame_starts.size() - base, 32'd17);

    // 5. Reset in the middle of the data bits with three bytes queued.
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    repeat (40) @(negedge clk);
    check("pre_reset_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx_async", {31'd0, tx}, 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    nframes = frame_starts.size();
    flat = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) flat = 1'b0;
    end
    check("post_reset_idle", {31'd0, flat}, 32'd1);
    check("post_reset_no_frame", frame_starts.size() - nframes, 32'd0);

`ifdef RS232_TX_PARITY_EN
    // 6. Parity frame: three ones in 0x07.
    base = frame_starts.size();
    push_byte(8'h07);
    drain("drain_parity");
    check("parity_frames", frame_starts.size() - base, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
